rf_wb_arbiter: RTL and testbench



---
 rtl/rf_wb_arbiter_if.sv | 42 ++++
 rtl/rf_wb_arbiter.sv | 67 ++++++
 tb/tb_rf_wb_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Write-back port bundle: two valid/ready requesters, a stall input, the
// register-file write port and the contention flag.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              stall;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;

  // Requester / register-file side of the arbiter.
  modport master (
    output stall,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_we, rf_addr, rf_wdata,
    input  busy
  );

  // The arbiter itself.
  modport slave (
    input  stall,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_we, rf_addr, rf_wdata,
    output busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU/jump result (req 0) and the load unit (req 1), with x0 filtering.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  rf_wb_arbiter_if.slave   bus
);

  logic              prio;      // 0: req 0 preferred on contention
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    win_addr = bus.req0_addr;
    win_data = bus.req0_data;

    if (rst_n && !bus.stall) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = (prio == 1'b0);
        grant1 = (prio == 1'b1);
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end

    if (grant1) begin
      win_addr = bus.req1_addr;
      win_data = bus.req1_data;
    end
  end

  // Readies are the grants themselves, so both are held low in reset/stall.
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.busy       = rst_n && ((bus.req0_valid && !grant0) ||
                                    (bus.req1_valid && !grant1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio         <= 1'b0;
      bus.rf_we    <= 1'b0;
      bus.rf_addr  <= '0;
      bus.rf_wdata <= '0;
    end else if (grant0 || grant1) begin
      prio         <= grant0;
      bus.rf_addr  <= win_addr;
      bus.rf_wdata <= win_data;
      // x0 writes are accepted but never reach the register file.
      bus.rf_we    <= (win_addr != '0);
    end else begin
      bus.rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a falling-edge register-file model
// observing the write port.
module tb_rf_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [DATA_W-1:0] regs [32];

  rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file commits on the falling edge inside the rf_we interval.
  initial for (int i = 0; i < 32; i++) regs[i] = '0;
  always @(negedge clk)
    if (bus.rf_we && bus.rf_addr != '0) regs[bus.rf_addr] <= bus.rf_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s,
                       input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.stall      = s;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    #1;
  endtask

  // Advance past the next rising edge; outputs are then sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic we,
                          input logic [4:0] a, input logic [31:0] d);
    check({tag, ".we"},    {31'd0, bus.rf_we}, {31'd0, we});
    check({tag, ".addr"},  {27'd0, bus.rf_addr}, {27'd0, a});
    check({tag, ".wdata"}, bus.rf_wdata, d);
  endtask

  task automatic check_hs(input string tag, input logic r0, input logic r1, input logic b);
    check({tag, ".ready0"}, {31'd0, bus.req0_ready}, {31'd0, r0});
    check({tag, ".ready1"}, {31'd0, bus.req1_ready}, {31'd0, r1});
    check({tag, ".busy"},   {31'd0, bus.busy},       {31'd0, b});
  endtask

  logic [4:0] cont_addr [4];
  logic       cont_r0   [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Reset held two cycles; readies and busy forced low even with valids up.
    tick();
    drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    check_rf("reset", 1'b0, 5'd0, 32'h0);
    check_hs("reset", 1'b0, 1'b0, 1'b0);
    tick();

    // Single write from req 0.
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    check_hs("single.req", 1'b1, 1'b0, 1'b0);
    check_rf("single.pre", 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    check_rf("single.wb", 1'b1, 5'd5, 32'hDEADBEEF);
    check_hs("single.idle", 1'b0, 1'b0, 1'b0);
    tick();
    check_rf("single.after", 1'b0, 5'd5, 32'hDEADBEEF);
    check("single.x5", regs[5], 32'hDEADBEEF);

    // x0 write from req 1 (prio is 1 here): accepted, rf_we stays low.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
    check_hs("x0.req", 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_rf("x0.wb", 1'b0, 5'd0, 32'hFFFFFFFF);
    tick();
    check("x0.read", regs[0], 32'h0);

    // Contention from prio 0: grants alternate 0,1,0,1.
    cont_addr = '{5'd1, 5'd2, 5'd1, 5'd2};
    cont_r0   = '{1'b1, 1'b0, 1'b1, 1'b0};
    drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    for (int k = 0; k < 4; k++) begin
      check_hs($sformatf("cont%0d", k), cont_r0[k], !cont_r0[k], 1'b1);
      tick();
      check_rf($sformatf("cont%0d", k), 1'b1, cont_addr[k],
               (cont_addr[k] == 5'd1) ? 32'h11 : 32'h22);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check_rf("cont.idle", 1'b0, 5'd2, 32'h22);
    check("cont.x2", regs[2], 32'h22);

    // Stall: set prio to 1 with a lone req 0 write, then stall both.
    drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    check_hs("stall0", 1'b0, 1'b0, 1'b1);
    check_rf("stall0", 1'b1, 5'd9, 32'h99);
    tick();
    check_hs("stall1", 1'b0, 1'b0, 1'b1);
    check_rf("stall1", 1'b0, 5'd9, 32'h99);
    tick();
    check_hs("stall2", 1'b0, 1'b0, 1'b1);
    check_rf("stall2", 1'b0, 5'd9, 32'h99);
    tick();
    drive(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    check_hs("unstall", 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_rf("unstall.wb", 1'b1, 5'd2, 32'h22);
    tick();

    // Same destination: req 0 (prio 0) first, then req 1; later grant wins.
    drive(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    check_hs("same0", 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    check_rf("same0", 1'b1, 5'd7, 32'hA);
    check_hs("same1", 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_rf("same1", 1'b1, 5'd7, 32'hB);
    tick();
    check("same.x7", regs[7], 32'hB);

    // Reset mid-stream: req 0 accepted at edge N, reset sampled at N+1.
    drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    check_hs("rstmid.req", 1'b1, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
    check_rf("rstmid.N", 1'b1, 5'd4, 32'h44);
    check_hs("rstmid.held", 1'b0, 1'b0, 1'b0);
    tick();
    check_rf("rstmid.N1", 1'b0, 5'd0, 32'h0);
    check_hs("rstmid.held2", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h33);
    check_hs("rstmid.prio", 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check_rf("rstmid.wb", 1'b1, 5'd6, 32'h66);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
